// File: rtl/ov7670_cfg_sequencer.sv
// OV7670 register configuration sequencer: walks a register ROM through the SCCB
// master after power-up, then arbitrates run-time user register writes onto it.
module ov7670_cfg_sequencer #(
    parameter int         CLOCK_FREQ = 12000000,
    parameter logic [7:0] SLAVE_ID   = 8'h42,
    parameter int         ROM_AW     = 8,
    parameter int         POWERUP_MS = 10,
    parameter bit         AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic              user_req,
    input  logic [7:0]        user_addr,
    input  logic [7:0]        user_data,
    output logic              user_ack,
    output logic              sccb_req,
    output logic [23:0]       sccb_send_data,
    input  logic              sccb_busy,
    output logic              init_done,
    output logic              seq_active,
    output logic [3:0]        fsm_state
);

    // Handshakes: sccb_req is held (with sccb_send_data stable) until sccb_busy is
    // sampled high; the transfer ends when sccb_busy is sampled low. user_req is a
    // level held with stable addr/data until the one-cycle user_ack.
    typedef enum logic [3:0] {
        S_IDLE, S_POWERUP, S_FETCH, S_DECODE, S_REQ,
        S_WAITB, S_DELAY, S_DONE, S_UREQ, S_UWAIT
    } state_t;

    localparam logic [31:0]       TICKS_PER_MS = 32'(CLOCK_FREQ / 1000);
    localparam logic [31:0]       PU_TICKS     = 32'(POWERUP_MS * (CLOCK_FREQ / 1000));
    localparam logic [ROM_AW-1:0] LAST_ADDR    = {ROM_AW{1'b1}};

    state_t            state, state_n;
    logic [ROM_AW-1:0] rom_addr_n;
    logic [23:0]       send_n;
    logic [31:0]       tick_cnt, tick_n;
    logic [7:0]        ms_cnt, ms_n;
    logic              ack_n;
    logic              start_pend, pend_n;
    logic              advance;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state          <= S_IDLE;
            rom_addr       <= '0;
            sccb_send_data <= '0;
            tick_cnt       <= '0;
            ms_cnt         <= '0;
            user_ack       <= 1'b0;
            start_pend     <= 1'b0;
        end else begin
            state          <= state_n;
            rom_addr       <= rom_addr_n;
            sccb_send_data <= send_n;
            tick_cnt       <= tick_n;
            ms_cnt         <= ms_n;
            user_ack       <= ack_n;
            start_pend     <= pend_n;
        end
    end

    always_comb begin
        state_n    = state;
        rom_addr_n = rom_addr;
        send_n     = sccb_send_data;
        tick_n     = tick_cnt;
        ms_n       = ms_cnt;
        ack_n      = 1'b0;
        pend_n     = start_pend;
        advance    = 1'b0;
        case (state)
            S_IDLE: begin
                if (AUTO_START || start) begin
                    state_n = S_POWERUP;
                    tick_n  = '0;
                end
            end
            S_POWERUP: begin
                if (tick_cnt + 32'd1 >= PU_TICKS) begin
                    tick_n     = '0;
                    rom_addr_n = '0;
                    state_n    = S_FETCH;
                end else begin
                    tick_n = tick_cnt + 32'd1;
                end
            end
            S_FETCH: state_n = S_DECODE;
            S_DECODE: begin
                if (rom_data == 16'hFFFF) begin
                    state_n = S_DONE;
                end else if (rom_data[15:8] == 8'hFE) begin
                    ms_n    = rom_data[7:0];
                    tick_n  = '0;
                    state_n = S_DELAY;
                end else begin
                    send_n  = {SLAVE_ID, rom_data};
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                if (sccb_busy) state_n = S_WAITB;
            end
            S_WAITB: begin
                if (!sccb_busy) advance = 1'b1;
            end
            S_DELAY: begin
                // The final millisecond advances on its last tick, so a delay of N ms
                // occupies exactly N*TICKS_PER_MS cycles; N=0 passes straight through.
                if (ms_cnt == 8'd0) begin
                    advance = 1'b1;
                end else if (tick_cnt + 32'd1 >= TICKS_PER_MS) begin
                    tick_n = '0;
                    ms_n   = ms_cnt - 8'd1;
                    if (ms_cnt == 8'd1) advance = 1'b1;
                end else begin
                    tick_n = tick_cnt + 32'd1;
                end
            end
            S_DONE: begin
                if (start || start_pend) begin
                    state_n = S_POWERUP;
                    tick_n  = '0;
                    pend_n  = 1'b0;
                end else if (user_req && !user_ack) begin
                    send_n  = {SLAVE_ID, user_addr, user_data};
                    state_n = S_UREQ;
                end
            end
            S_UREQ: begin
                if (start) pend_n = 1'b1;
                if (sccb_busy) state_n = S_UWAIT;
            end
            S_UWAIT: begin
                if (start) pend_n = 1'b1;
                if (!sccb_busy) begin
                    ack_n   = 1'b1;
                    state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Running off the end of the ROM acts as an implicit END entry.
        if (advance) begin
            if (rom_addr == LAST_ADDR) begin
                state_n = S_DONE;
            end else begin
                rom_addr_n = rom_addr + 1'b1;
                state_n    = S_FETCH;
            end
        end
    end

    assign sccb_req   = (state == S_REQ) || (state == S_UREQ);
    assign init_done  = (state == S_DONE) || (state == S_UREQ) || (state == S_UWAIT);
    assign seq_active = (state == S_POWERUP) || (state == S_FETCH) || (state == S_DECODE) ||
                        (state == S_REQ) || (state == S_WAITB) || (state == S_DELAY);
    assign fsm_state  = state;

endmodule
